// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// Used by both ends of the link so frame format stays in one place.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, rst (async high), d (async in), q (synchronized out).
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8N1, oversampled bit timer, valid/ack handshake.
// Ports: clk, rst, rx in; data/valid/frame_err/overrun/busy out; ack in.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    input  logic                      ack,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(UART_DATA_BITS);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_TOP = BW'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync #(
        .RST_VAL(UART_IDLE_LEVEL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    rx_state_t                 state, state_next;
    logic [CW-1:0]             cnt;
    logic [BW-1:0]             bitcnt;
    logic [UART_DATA_BITS-1:0] shreg;

    logic cnt_clr;
    logic shift_en;
    logic load;
    logic ferr;

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        load       = 1'b0;
        ferr       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                    cnt_clr    = 1'b1;
                end
            end
            ST_START: begin
                if (cnt == HALF_M1) begin
                    cnt_clr    = 1'b1;
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bitcnt == BIT_TOP)
                        state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        load       = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ferr       = 1'b1;
                        state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    cnt_clr    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Timer only runs in the timed states so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            if (cnt_clr || state == ST_IDLE || state == ST_BREAK)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (state == ST_IDLE)
                bitcnt <= '0;
            else if (shift_en)
                bitcnt <= bitcnt + BW'(1);

            // LSB arrives first, so shift in from the top.
            if (shift_en)
                shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
        end
    end

    // A load on the same edge as ack wins; overrun only when the
    // previous byte was still pending and not being taken now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= ferr;
            busy      <= (state_next != ST_IDLE);
            if (load) begin
                data    <= shreg;
                valid   <= 1'b1;
                overrun <= valid && !ack;
            end else if (ack) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule
